fifo_drain: RTL

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_drain_if.sv | 34 +++
 rtl/fifo_drain_occ_counter.sv | 48 ++++
 rtl/fifo_drain.sv | 89 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and the drain FSM state type for the FIFO drain block.
// The drain pops one wide FIFO entry and emits it one word (lane) at a time.
package fifo_pkg;

    localparam int FIFO_WIDTH_ADR  = 2;
    localparam int FIFO_WIDTH_WORD = 72;
    localparam int FIFO_LANES      = 4;
    localparam int FIFO_DEPTH      = 2 ** FIFO_WIDTH_ADR;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_drain_if.sv
// Bundle of FIFO-side and stream-side signals for fifo_drain.
// The master modport is the environment (FIFO producer plus downstream sink).
// The slave modport is the drain block itself.
interface fifo_drain_if #(
    parameter int WIDTH_ADR  = fifo_pkg::FIFO_WIDTH_ADR,
    parameter int WIDTH_WORD = fifo_pkg::FIFO_WIDTH_WORD,
    parameter int LANES      = fifo_pkg::FIFO_LANES
) ();
    import fifo_pkg::*;

    logic                        fifo_write_en;
    logic                        fifo_read_en;
    logic [WIDTH_WORD*LANES-1:0] fifo_read_dt;
    // A word transfers on every rising clk edge where out_valid && out_ready are both high.
    // While out_valid is high and out_ready is low, out_data and out_last hold their values.
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH_WORD-1:0]       out_data;
    logic                        out_last;
    logic [WIDTH_ADR:0]          count;
    logic                        overflow;
    state_e                      state;

    modport master (
        output fifo_write_en, fifo_read_dt, out_ready,
        input  fifo_read_en, out_valid, out_data, out_last, count, overflow, state
    );

    modport slave (
        input  fifo_write_en, fifo_read_dt, out_ready,
        output fifo_read_en, out_valid, out_data, out_last, count, overflow, state
    );

endinterface

// File: rtl/fifo_drain_occ_counter.sv
// Saturating up/down count of entries held in the FIFO.
// A sticky overflow flag is raised by any write that lands on a full FIFO.
module occ_counter #(
    parameter int WIDTH_ADR = fifo_pkg::FIFO_WIDTH_ADR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [WIDTH_ADR:0] count_o,
    output logic               overflow_o
);

    localparam logic [WIDTH_ADR:0] DEPTH = {1'b1, {WIDTH_ADR{1'b0}}};
    localparam logic [WIDTH_ADR:0] ONE   = {{WIDTH_ADR{1'b0}}, 1'b1};

    logic [WIDTH_ADR:0] count_q, count_d;
    logic               overflow_q, overflow_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // A write and a read in the same cycle cancel, even when the FIFO is full.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (inc_i && !dec_i) begin
            if (count_q == DEPTH) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/fifo_drain.sv
// Pops one wide entry from the FIFO and streams it out lane 0 first.
// The stream is valid/ready; the entry is held while downstream stalls.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH_ADR  = FIFO_WIDTH_ADR,
    parameter int WIDTH_WORD = FIFO_WIDTH_WORD,
    parameter int LANES      = FIFO_LANES
) (
    input  logic         clk,
    input  logic         rst,
    fifo_drain_if.slave  bus
);

    localparam int             LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int             EW        = WIDTH_WORD * LANES;
    localparam logic [LW-1:0]  LAST_LANE = LW'(LANES - 1);

    state_e             state_q, state_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic [EW-1:0]      entry_q, entry_d;
    logic [WIDTH_ADR:0] count;
    logic               overflow;
    logic               read_en;

    occ_counter #(
        .WIDTH_ADR (WIDTH_ADR)
    ) u_occ (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (bus.fifo_write_en),
        .dec_i      (read_en),
        .count_o    (count),
        .overflow_o (overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            entry_q <= entry_d;
        end
    end

    // FETCH is only entered with count > 0, so the read strobe never hits an empty FIFO.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        entry_d = entry_q;
        read_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) state_d = FETCH;
            end
            FETCH: begin
                read_en = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                entry_d = bus.fifo_read_dt;
                lane_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bus.out_ready) begin
                    if (lane_q == LAST_LANE) begin
                        state_d = (count != '0) ? FETCH : IDLE;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.fifo_read_en = read_en;
    assign bus.out_valid    = (state_q == SHIFT);
    assign bus.out_data     = (state_q == SHIFT) ? entry_q[lane_q*WIDTH_WORD +: WIDTH_WORD] : '0;
    assign bus.out_last     = (state_q == SHIFT) && (lane_q == LAST_LANE);
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.state        = state_q;

endmodule
